// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb_4.sv
// gf180mcu_fd_sc_mcu7t5v0__rrarb_4: 4-way round-robin arbiter with hold limit and one-cycle release gap
module gf180mcu_fd_sc_mcu7t5v0__rrarb_4 #(
  parameter int MAXHOLD = 16
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       ANY,
  output logic       PREEMPT,
  inout  wire        VDD,
  inout  wire        VSS
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;
  state_t     r_state, w_state_nx;
  logic [1:0] r_ptr, w_pick, w_owner_nx;
  logic [7:0] r_hcnt, w_hcnt_nx;
  logic [3:0] w_gnt_nx;
  logic       w_own_req, w_others, w_preempt, w_arb;
  assign ANY       = |REQ;
  assign w_own_req = REQ[r_ptr];
  assign w_others  = |(REQ & ~(4'b0001 << r_ptr));
  assign w_preempt = (r_state == S_GRANT) && w_own_req && (r_hcnt == 8'(MAXHOLD)) && w_others;
  assign w_arb     = (r_state != S_GRANT) && ANY;
  // First requester after the pointer wins; the pointer's own index ranks last
  always_comb begin
    w_pick = r_ptr;
    for (int i = 4; i >= 1; i--)
      if (REQ[r_ptr + 2'(i)]) w_pick = r_ptr + 2'(i);
  end
  // State register
  always_ff @(posedge CLK)
    if (!RN) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  // Next state: a grant ends on owner release or hold-limit revocation, always through one GAP
  always_comb
    w_state_nx = (r_state == S_GRANT) ? ((!w_own_req || w_preempt) ? S_GAP : S_GRANT)
                                      : (ANY ? S_GRANT : S_IDLE);
  // Next values of the registered outputs and hold counter
  always_comb begin
    w_gnt_nx   = w_arb ? (4'b0001 << w_pick) : ((w_state_nx == S_GRANT) ? GNT : 4'b0000);
    w_owner_nx = w_arb ? w_pick : OWNER;
    w_hcnt_nx  = w_arb ? 8'd1
               : ((w_state_nx == S_GRANT) && (r_hcnt < 8'(MAXHOLD))) ? r_hcnt + 8'd1 : r_hcnt;
  end
  // Output and pointer registers; OWNER and pointer keep the last winner through GAP and IDLE
  always_ff @(posedge CLK)
    if (!RN) begin
      GNT     <= 4'b0000;
      OWNER   <= 2'd3;
      r_ptr   <= 2'd3;
      r_hcnt  <= 8'd0;
      BUSY    <= 1'b0;
      PREEMPT <= 1'b0;
    end else begin
      GNT     <= w_gnt_nx;
      OWNER   <= w_owner_nx;
      r_ptr   <= w_owner_nx;
      r_hcnt  <= w_hcnt_nx;
      BUSY    <= |w_gnt_nx;
      PREEMPT <= w_preempt;
    end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb_4.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__rrarb_4: directed self-checking bench for the round-robin arbiter
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb_4;
  logic       CLK = 1'b0;
  logic       RN  = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUSY, ANY, PREEMPT;
  wire        VDD, VSS;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] prev_gnt;
  assign VDD = 1'b1;
  assign VSS = 1'b0;
  gf180mcu_fd_sc_mcu7t5v0__rrarb_4 #(.MAXHOLD(16)) dut (
    .CLK(CLK), .RN(RN), .REQ(REQ), .GNT(GNT), .OWNER(OWNER), .BUSY(BUSY),
    .ANY(ANY), .PREEMPT(PREEMPT), .VDD(VDD), .VSS(VSS)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] o, input logic p);
    chk({tag, "_gnt"}, 8'(GNT), 8'(g));
    chk({tag, "_owner"}, 8'(OWNER), 8'(o));
    chk({tag, "_busy"}, 8'(BUSY), 8'(|g));
    chk({tag, "_preempt"}, 8'(PREEMPT), 8'(p));
  endtask
  initial begin
    step();
    step();
    chk_out("reset", 4'b0000, 2'd3, 1'b0);
    chk("reset_any", 8'(ANY), 8'd0);
    REQ = 4'b0101;
    #1;
    chk("any_in_reset", 8'(ANY), 8'd1);
    RN  = 1'b1;
    REQ = 4'b1111;
    step();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk_out("hold0", 4'b0001, 2'd0, 1'b0);
    end
    step();
    chk_out("preempt_gap", 4'b0000, 2'd0, 1'b1);
    step();
    chk_out("after_preempt", 4'b0010, 2'd1, 1'b0);
    REQ = 4'b1001;
    step();
    chk_out("release_gap", 4'b0000, 2'd1, 1'b0);
    step();
    chk_out("next_is_3", 4'b1000, 2'd3, 1'b0);
    REQ = 4'b0000;
    step();
    chk_out("gap_to_idle", 4'b0000, 2'd3, 1'b0);
    step();
    chk_out("idle", 4'b0000, 2'd3, 1'b0);
    REQ = 4'b0100;
    step();
    chk_out("req2_c1", 4'b0100, 2'd2, 1'b0);
    step();
    chk_out("req2_c2", 4'b0100, 2'd2, 1'b0);
    step();
    chk_out("req2_c3", 4'b0100, 2'd2, 1'b0);
    REQ = 4'b0000;
    step();
    chk_out("req2_gap", 4'b0000, 2'd2, 1'b0);
    step();
    chk_out("req2_idle", 4'b0000, 2'd2, 1'b0);
    REQ = 4'b0100;
    step();
    chk_out("solo_grant", 4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step();
      chk_out("solo_hold", 4'b0100, 2'd2, 1'b0);
    end
    chk("hcnt_sat", dut.r_hcnt, 8'd16);
    REQ = 4'b0010;
    step();
    chk_out("solo_release", 4'b0000, 2'd2, 1'b0);
    step();
    chk_out("grant1", 4'b0010, 2'd1, 1'b0);
    step();
    chk_out("grant1_hold", 4'b0010, 2'd1, 1'b0);
    RN = 1'b0;
    step();
    chk_out("mid_reset", 4'b0000, 2'd3, 1'b0);
    RN = 1'b1;
    step();
    chk_out("post_reset", 4'b0010, 2'd1, 1'b0);
    REQ = 4'b0011;
    step();
    chk_out("pulse0", 4'b0010, 2'd1, 1'b0);
    REQ = 4'b0010;
    step();
    chk_out("pulse0_gone", 4'b0010, 2'd1, 1'b0);
    REQ = 4'b0000;
    step();
    chk_out("rel1", 4'b0000, 2'd1, 1'b0);
    step();
    chk_out("not_remembered", 4'b0000, 2'd1, 1'b0);
    prev_gnt = GNT;
    for (int i = 0; i < 1000; i++) begin
      REQ = 4'($urandom_range(0, 15));
      step();
      chk("rnd_onehot0", 8'($onehot0(GNT)), 8'd1);
      chk("rnd_busy", 8'(BUSY), 8'(|GNT));
      chk("rnd_any", 8'(ANY), 8'(|REQ));
      chk("rnd_no_switch", 8'((prev_gnt != 4'b0000) && (GNT != 4'b0000) && (GNT != prev_gnt)), 8'd0);
      prev_gnt = GNT;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
